// File: rtl/byte_assembler.sv
// Assembles an MSB-first byte stream into 32-bit words and flags frame completion after n words.
// Optional running XOR checksum of the frame's words: define BYTE_ASM_CHECKSUM_EN.
module byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        asm_en,
    input  logic [7:0]  n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic [7:0]  word_count,
    output logic        asm_done,
    output logic [31:0] chk_out
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned PART_W = WORD_W - BYTE_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    n_lat, n_lat_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [PART_W-1:0]   part, part_nxt;
    logic [WORD_W-1:0]   word_nxt;
    logic                word_valid_nxt;
    logic [CNT_W-1:0]    count_nxt;
    logic [CNT_W-1:0]    count_inc;
    logic                done_nxt;
    logic [WORD_W-1:0]   word_asm;
`ifdef BYTE_ASM_CHECKSUM_EN
    logic [WORD_W-1:0]   chk, chk_nxt;
`endif

    assign count_inc = CNT_W'(word_count + CNT_W'(1));
    assign word_asm  = {part, byte_in};

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            n_lat      <= '0;
            idx        <= '0;
            part       <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            word_count <= '0;
            asm_done   <= 1'b0;
`ifdef BYTE_ASM_CHECKSUM_EN
            chk        <= '0;
`endif
        end else begin
            state      <= state_nxt;
            n_lat      <= n_lat_nxt;
            idx        <= idx_nxt;
            part       <= part_nxt;
            word_out   <= word_nxt;
            word_valid <= word_valid_nxt;
            word_count <= count_nxt;
            asm_done   <= done_nxt;
`ifdef BYTE_ASM_CHECKSUM_EN
            chk        <= chk_nxt;
`endif
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_nxt      = state;
        n_lat_nxt      = n_lat;
        idx_nxt        = idx;
        part_nxt       = part;
        word_nxt       = word_out;
        word_valid_nxt = 1'b0;
        count_nxt      = word_count;
`ifdef BYTE_ASM_CHECKSUM_EN
        chk_nxt        = chk;
`endif
        unique case (state)
            IDLE: begin
                if (asm_en) begin
                    n_lat_nxt = n;
                    idx_nxt   = '0;
                    count_nxt = '0;
`ifdef BYTE_ASM_CHECKSUM_EN
                    chk_nxt   = '0;
`endif
                    state_nxt = (n == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (asm_en && byte_valid) begin
                    idx_nxt = IDX_W'(idx + IDX_W'(1));
                    unique case (idx)
                        2'd0: part_nxt[23:16] = byte_in;
                        2'd1: part_nxt[15:8]  = byte_in;
                        2'd2: part_nxt[7:0]   = byte_in;
                        default: begin
                            word_nxt       = word_asm;
                            word_valid_nxt = 1'b1;
                            count_nxt      = count_inc;
`ifdef BYTE_ASM_CHECKSUM_EN
                            chk_nxt        = chk ^ word_asm;
`endif
                            if (count_inc == n_lat) begin
                                state_nxt = DONE;
                            end
                        end
                    endcase
                end
            end
            DONE: begin
                if (!asm_en) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        done_nxt = (state_nxt == DONE);
    end

`ifdef BYTE_ASM_CHECKSUM_EN
    assign chk_out = chk;
`else
    assign chk_out = '0;
`endif

endmodule

// File: tb/tb_byte_assembler.sv
// Directed self-checking bench for byte_assembler; expected values are hand-computed.
module tb_byte_assembler;
    logic        clk;
    logic        rst_n;
    logic        asm_en;
    logic [7:0]  n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [31:0] word_out;
    logic        word_valid;
    logic [7:0]  word_count;
    logic        asm_done;
    logic [31:0] chk_out;

    int vectors = 0;
    int errors  = 0;

    byte_assembler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .asm_en     (asm_en),
        .n          (n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_count (word_count),
        .asm_done   (asm_done),
        .chk_out    (chk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
    endtask

    // Expected checksum depends on build
    function automatic logic [31:0] exp_chk(input logic [31:0] v);
`ifdef BYTE_ASM_CHECKSUM_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    initial begin
        rst_n = 1'b0; asm_en = 1'b0; n = 8'd0; byte_in = 8'd0; byte_valid = 1'b0;
        #1;
        check("rst_word_out",   word_out, 32'h0);
        check("rst_word_valid", 32'(word_valid), 32'h0);
        check("rst_word_count", 32'(word_count), 32'h0);
        check("rst_asm_done",   32'(asm_done), 32'h0);
        check("rst_chk_out",    chk_out, 32'h0);
        step(); step();
        #2 rst_n = 1'b1;
        step();

        // Single word, back-to-back bytes
        n = 8'd1; asm_en = 1'b1;
        step();
        check("t1_start_count", 32'(word_count), 32'h0);
        check("t1_start_done",  32'(asm_done), 32'h0);
        byte_in = 8'hDE; byte_valid = 1'b1; step();
        check("t1_b0_valid", 32'(word_valid), 32'h0);
        byte_in = 8'hAD; step();
        byte_in = 8'hBE; step();
        check("t1_b2_valid", 32'(word_valid), 32'h0);
        byte_in = 8'hEF; step();
        check("t1_word",  word_out, 32'hDEADBEEF);
        check("t1_valid", 32'(word_valid), 32'h1);
        check("t1_done",  32'(asm_done), 32'h1);
        check("t1_count", 32'(word_count), 32'h1);
        check("t1_chk",   chk_out, exp_chk(32'hDEADBEEF));
        byte_in = 8'hFF; step();
        check("t1_done_valid", 32'(word_valid), 32'h0);
        check("t1_done_hold",  word_out, 32'hDEADBEEF);
        check("t1_done_count", 32'(word_count), 32'h1);
        check("t1_done_held",  32'(asm_done), 32'h1);
        byte_valid = 1'b0; asm_en = 1'b0; step();
        check("t1_idle_done", 32'(asm_done), 32'h0);
        check("t1_idle_word", word_out, 32'hDEADBEEF);

        // Two words with idle gaps
        n = 8'd2; asm_en = 1'b1;
        step();
        check("t2_start_count", 32'(word_count), 32'h0);
        send(8'h11); step();
        send(8'h22); step();
        send(8'h33); step();
        send(8'h44);
        check("t2_w0",       word_out, 32'h11223344);
        check("t2_w0_valid", 32'(word_valid), 32'h1);
        check("t2_w0_count", 32'(word_count), 32'h1);
        check("t2_w0_done",  32'(asm_done), 32'h0);
        step();
        check("t2_gap_valid", 32'(word_valid), 32'h0);
        send(8'h55); step();
        send(8'h66); step();
        send(8'h77); step();
        send(8'h88);
        check("t2_w1",       word_out, 32'h55667788);
        check("t2_w1_valid", 32'(word_valid), 32'h1);
        check("t2_w1_count", 32'(word_count), 32'h2);
        check("t2_w1_done",  32'(asm_done), 32'h1);
        check("t2_chk",      chk_out, exp_chk(32'h444444CC));
        asm_en = 1'b0; step();
        check("t2_idle_done", 32'(asm_done), 32'h0);

        // Pause mid-word; bytes offered while paused must be dropped
        n = 8'd1; asm_en = 1'b1;
        step();
        send(8'hA1);
        send(8'hB2);
        byte_in = 8'hFF; byte_valid = 1'b1; asm_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_pause_valid", 32'(word_valid), 32'h0);
            byte_valid = ~byte_valid;
            byte_in    = 8'(byte_in - 8'h11);
        end
        check("t3_pause_count", 32'(word_count), 32'h0);
        check("t3_pause_done",  32'(asm_done), 32'h0);
        asm_en = 1'b1;
        send(8'hC3);
        check("t3_c3_valid", 32'(word_valid), 32'h0);
        send(8'hD4);
        check("t3_word",  word_out, 32'hA1B2C3D4);
        check("t3_valid", 32'(word_valid), 32'h1);
        check("t3_done",  32'(asm_done), 32'h1);
        asm_en = 1'b0; step();

        // Zero-length frame
        n = 8'd0; asm_en = 1'b1;
        step();
        check("t4_done",  32'(asm_done), 32'h1);
        check("t4_valid", 32'(word_valid), 32'h0);
        check("t4_count", 32'(word_count), 32'h0);
        check("t4_chk",   chk_out, 32'h0);
        send(8'h5A);
        check("t4_ignore_valid", 32'(word_valid), 32'h0);
        check("t4_ignore_word",  word_out, 32'hA1B2C3D4);
        asm_en = 1'b0; step();
        check("t4_clear_done", 32'(asm_done), 32'h0);

        // Reset mid-frame clears asynchronously
        n = 8'd1; asm_en = 1'b1;
        step();
        send(8'h01);
        send(8'h02);
        send(8'h03);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_word",  word_out, 32'h0);
        check("t5_rst_count", 32'(word_count), 32'h0);
        check("t5_rst_done",  32'(asm_done), 32'h0);
        check("t5_rst_chk",   chk_out, 32'h0);
        asm_en = 1'b0;
        step();
        #2 rst_n = 1'b1;
        step();
        n = 8'd1; asm_en = 1'b1;
        step();
        send(8'h0A);
        send(8'h0B);
        send(8'h0C);
        send(8'h0D);
        check("t5_word",  word_out, 32'h0A0B0C0D);
        check("t5_count", 32'(word_count), 32'h1);
        check("t5_done",  32'(asm_done), 32'h1);

        // Re-arm with n=3; n changed mid-frame must be ignored
        asm_en = 1'b0; step();
        check("t6_idle_done", 32'(asm_done), 32'h0);
        n = 8'd3; asm_en = 1'b1;
        step();
        check("t6_restart_count", 32'(word_count), 32'h0);
        n = 8'd1;
        send(8'h10); send(8'h20); send(8'h30); send(8'h40);
        check("t6_w0",      word_out, 32'h10203040);
        check("t6_w0_cnt",  32'(word_count), 32'h1);
        check("t6_w0_done", 32'(asm_done), 32'h0);
        send(8'h50); send(8'h60); send(8'h70); send(8'h80);
        check("t6_w1",      word_out, 32'h50607080);
        check("t6_w1_cnt",  32'(word_count), 32'h2);
        check("t6_w1_done", 32'(asm_done), 32'h0);
        send(8'h90); send(8'hA0); send(8'hB0); send(8'hC0);
        check("t6_w2",      word_out, 32'h90A0B0C0);
        check("t6_w2_cnt",  32'(word_count), 32'h3);
        check("t6_w2_done", 32'(asm_done), 32'h1);
        check("t6_chk",     chk_out, exp_chk(32'hD0E0F000));
        asm_en = 1'b0; step();

        // Maximum length: n=255 ends at count 255 without wrapping
        n = 8'd255; asm_en = 1'b1;
        step();
        for (int w = 1; w <= 255; w++) begin
            for (int b = 0; b < 4; b++) begin
                byte_in = 8'(w); byte_valid = 1'b1;
                step();
            end
            if (w == 254) begin
                check("t7_w254_cnt",  32'(word_count), 32'd254);
                check("t7_w254_done", 32'(asm_done), 32'h0);
            end
        end
        byte_valid = 1'b0;
        check("t7_w255",      word_out, 32'hFFFFFFFF);
        check("t7_w255_cnt",  32'(word_count), 32'd255);
        check("t7_w255_done", 32'(asm_done), 32'h1);
        check("t7_chk",       chk_out, 32'h0);
        step();
        check("t7_hold_cnt", 32'(word_count), 32'd255);
        asm_en = 1'b0; step();
        check("t7_idle_done", 32'(asm_done), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
